rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Writeback arbiter and scoreboard for the register file's single write port.
- Accepts writeback requests from NREQ producers (ALU, LSU, MDU), grants one per cycle round-robin, and drives registered WE/AW/D into the register file.
- Tracks pending destination registers and reports hazards to the issue stage.
- Sits between the execute units and the register file.

Parameters:
- NREQ, 3, number of writeback requesters (index 0=ALU, 1=LSU, 2=MDU).
- XLEN, 32, data width.
- RAW, 5, register address width (32 registers).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- REQ_V  in  NREQ  per-requester writeback valid.
- REQ_RD  in  NREQ*RAW  per-requester destination, requester i at bits [i*RAW +: RAW].
- REQ_D  in  NREQ*XLEN  per-requester data, requester i at [i*XLEN +: XLEN].
- REQ_RDY  out  NREQ  one-hot grant; combinational from REQ_V and PTR.
- WE  out  1  register file write enable; registered.
- AW  out  RAW  register file write address; registered.
- D  out  XLEN  register file write data; registered.
- ISSUE_V  in  1  issue stage presents an instruction this cycle.
- ISSUE_RD  in  RAW  its destination (0 = no writeback).
- RS1, RS2  in  RAW  its source registers.
- HAZARD  out  1  combinational: BUSY[RS1] | BUSY[RS2] | BUSY[ISSUE_RD].
- BUSY  out  32  scoreboard; bit 0 is constant 0.

Behaviour:
- Reset (RSTN=0, async): WE=0, AW=0, D=0, BUSY=0, PTR=0. Requests in flight are dropped. REQ_RDY is all-zero while RSTN=0.
- Arbitration:
  - Grant goes to the first i with REQ_V[i]=1, searching from PTR upward mod NREQ. At most one REQ_RDY bit is set; none when no REQ_V.
  - Transfer occurs when REQ_V[i] & REQ_RDY[i]. On that edge PTR becomes (i+1) mod NREQ. PTR holds when nothing transfers.
  - Requesters hold REQ_V/REQ_RD/REQ_D stable until granted. Deasserting REQ_V before grant is legal.
- Write latency: 1 cycle. On the transfer edge: WE <= (rd != 0), AW <= rd, D <= data. With no transfer, WE <= 0 and AW/D hold.
- Throughput: 1 write per cycle; no internal buffering.
- Scoreboard:
  - Set BUSY[ISSUE_RD] on an edge where ISSUE_V=1, HAZARD=0 and ISSUE_RD != 0.
  - Clear BUSY[AW] on an edge where WE=1. This is the same edge the register file commits the write, so a source read in the following cycle sees the new value.
  - Set and clear of the same register on the same edge: set wins.
  - ISSUE_V while HAZARD=1: no scoreboard change. The issue stage stalls.
  - Write to x0: accepted and granted, WE stays 0, no scoreboard effect.
- HAZARD counts the WAW case (BUSY[ISSUE_RD]) so results from different producers retire in order. It does not depend on ISSUE_V.
- Write to a register whose BUSY=0 (protocol violation): still performed. Bench flags it as an assertion error.

Decomposition:
- Shared package rf_pkg: XLEN, RAW, NREGS=32, requester index constants REQ_ALU=0, REQ_LSU=1, REQ_MDU=2.
- Sub-module rr_arbiter (NREQ-wide round-robin grant plus pointer register), reusable for memory-port sharing.
- Scoreboard and write registers stay in the top.

Test Plan:
- Reset: assert RSTN=0 mid-transfer (REQ_V=3'b001) -> WE=0, BUSY=0, REQ_RDY=0 immediately, without waiting for a clock edge.
- Single write: ISSUE_V, ISSUE_RD=5 -> BUSY[5]=1. Then ALU REQ_V, rd=5, D=32'hDEADBEEF -> REQ_RDY=3'b001. Next cycle WE=1, AW=5, D=32'hDEADBEEF. Following cycle BUSY[5]=0.
- Round-robin: all three REQ_V held with rd=1,2,3 from PTR=0 -> grants in order 001, 010, 100 on consecutive cycles, AW=1,2,3. Hold REQ_V[0], REQ_V[2] for another round -> grants 001, 100.
- Hazard: BUSY[7]=1, RS1=7 -> HAZARD=1 and ISSUE_V with ISSUE_RD=9 leaves BUSY[9]=0. RS1=RS2=ISSUE_RD=0 -> HAZARD=0.
- Same-edge set/clear: WE=1, AW=4 on the same edge as ISSUE_V, ISSUE_RD=4 with HAZARD forced 0 via separate rs -> BUSY[4]=1 afterwards.
- x0: REQ_V, rd=0, D=32'h1234 -> granted, WE stays 0, BUSY unchanged.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback path.
//   XLEN / RAW / NREGS : data width, register address width, register count
//   NREQ               : number of writeback producers
//   REQ_ALU/LSU/MDU    : fixed requester slot indices
//   reg_mask()         : one-hot mask selecting a single register
package rf_pkg;

    localparam int XLEN    = 32;
    localparam int RAW     = 5;
    localparam int NREGS   = 32;
    localparam int NREQ    = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

    // One-hot register mask; used for scoreboard set/clear.
    function automatic logic [NREGS-1:0] reg_mask(input logic [RAW-1:0] r);
        logic [NREGS-1:0] m;
        m    = {NREGS{1'b0}};
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter with an internal priority pointer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : per-requester request lines
//   gnt_o         : one-hot grant (combinational), all-zero during reset
//   sel_o         : index of the granted requester
//   valid_o       : a grant is being issued this cycle
// The search starts at the pointer and wraps; after a grant the pointer moves
// just past the winner. Since a grant is only given to an active request,
// any grant is a transfer.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic [PW-1:0] sel_o,
    output logic         valid_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [N-1:0]  gnt_s;
    logic [PW-1:0] sel_s;
    logic          found_s;
    logic [PW-1:0] idx_s;
    logic          hit_s;
    int            sum_s;

    // Priority search from the pointer upward, modulo N.
    always_comb begin
        gnt_s   = {N{1'b0}};
        sel_s   = {PW{1'b0}};
        found_s = 1'b0;
        idx_s   = {PW{1'b0}};
        hit_s   = 1'b0;
        sum_s   = 0;
        for (int k = 0; k < N; k++) begin
            sum_s        = int'(ptr_q) + k;
            idx_s        = (sum_s >= N) ? PW'(sum_s - N) : PW'(sum_s);
            hit_s        = ~found_s & req_i[idx_s];
            gnt_s[idx_s] = gnt_s[idx_s] | hit_s;
            sel_s        = hit_s ? idx_s : sel_s;
            found_s      = found_s | hit_s;
        end
    end

    // Grant is suppressed while reset is asserted, independent of the clock.
    always_comb begin
        gnt_o   = rst_ni ? gnt_s : {N{1'b0}};
        sel_o   = sel_s;
        valid_o = |gnt_o;
    end

    // Next pointer: one past the winner, otherwise hold.
    always_comb begin
        ptr_d = valid_o ? ((sel_s == PW'(N - 1)) ? {PW{1'b0}} : sel_s + PW'(1)) : ptr_q;
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= {PW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter and scoreboard for the register file's single write port.
//   CLK, RSTN              : clock, asynchronous active-low reset
//   REQ_V/REQ_RD/REQ_D     : per-producer writeback request (packed by index)
//   REQ_RDY                : one-hot grant, combinational
//   WE/AW/D                : registered register-file write port
//   ISSUE_V/ISSUE_RD       : instruction being issued and its destination
//   RS1/RS2                : its source registers
//   HAZARD                 : any source or destination still pending
//   BUSY                   : pending-destination scoreboard, bit 0 always 0
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ_P = NREQ,
    parameter int XLEN_P = XLEN,
    parameter int RAW_P  = RAW
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic [NREQ_P-1:0]        REQ_V,
    input  logic [NREQ_P*RAW_P-1:0]  REQ_RD,
    input  logic [NREQ_P*XLEN_P-1:0] REQ_D,
    output logic [NREQ_P-1:0]        REQ_RDY,
    output logic                     WE,
    output logic [RAW_P-1:0]         AW,
    output logic [XLEN_P-1:0]        D,
    input  logic                     ISSUE_V,
    input  logic [RAW_P-1:0]         ISSUE_RD,
    input  logic [RAW_P-1:0]         RS1,
    input  logic [RAW_P-1:0]         RS2,
    output logic                     HAZARD,
    output logic [NREGS-1:0]         BUSY
);

    localparam int PW = (NREQ_P > 1) ? $clog2(NREQ_P) : 1;

    logic [NREQ_P-1:0] gnt_s;
    logic [PW-1:0]     sel_s;
    logic              xfer_s;
    logic [RAW_P-1:0]  rd_s;
    logic [XLEN_P-1:0] data_s;

    logic              we_q;
    logic              we_d;
    logic [RAW_P-1:0]  aw_q;
    logic [RAW_P-1:0]  aw_d;
    logic [XLEN_P-1:0] d_q;
    logic [XLEN_P-1:0] d_d;

    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [NREGS-1:0]  set_mask_s;
    logic [NREGS-1:0]  clr_mask_s;
    logic              hazard_s;
    logic              issue_ok_s;

    rr_arbiter #(
        .N (NREQ_P)
    ) u_rr (
        .clk_i   (CLK),
        .rst_ni  (RSTN),
        .req_i   (REQ_V),
        .gnt_o   (gnt_s),
        .sel_o   (sel_s),
        .valid_o (xfer_s)
    );

    // Select the winning requester's destination and data.
    always_comb begin
        rd_s   = REQ_RD[int'(sel_s)*RAW_P +: RAW_P];
        data_s = REQ_D[int'(sel_s)*XLEN_P +: XLEN_P];
    end

    // Write-port next state: x0 writes are granted but never enable the port.
    always_comb begin
        we_d = xfer_s & (rd_s != {RAW_P{1'b0}});
        aw_d = xfer_s ? rd_s : aw_q;
        d_d  = xfer_s ? data_s : d_q;
    end

    // Write-port registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            we_q <= 1'b0;
            aw_q <= {RAW_P{1'b0}};
            d_q  <= {XLEN_P{1'b0}};
        end else begin
            we_q <= we_d;
            aw_q <= aw_d;
            d_q  <= d_d;
        end
    end

    // Hazard covers sources and the destination (WAW keeps retirement in order).
    always_comb begin
        hazard_s   = busy_q[RS1] | busy_q[RS2] | busy_q[ISSUE_RD];
        issue_ok_s = ISSUE_V & ~hazard_s & (ISSUE_RD != {RAW_P{1'b0}});
    end

    // Scoreboard next state: clear the register being committed, then apply
    // the issue set so a same-edge set/clear leaves the register busy.
    always_comb begin
        clr_mask_s = we_q ? reg_mask(aw_q) : {NREGS{1'b0}};
        set_mask_s = issue_ok_s ? reg_mask(ISSUE_RD) : {NREGS{1'b0}};
        busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~{{(NREGS-1){1'b0}}, 1'b1};
    end

    // Scoreboard register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            busy_q <= {NREGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    // Output drive.
    always_comb begin
        REQ_RDY = gnt_s;
        WE      = we_q;
        AW      = aw_q;
        D       = d_q;
        HAZARD  = hazard_s;
        BUSY    = busy_q;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    logic        CLK;
    logic        RSTN;
    logic [2:0]  REQ_V;
    logic [14:0] REQ_RD;
    logic [95:0] REQ_D;
    logic [2:0]  REQ_RDY;
    logic        WE;
    logic [4:0]  AW;
    logic [31:0] D;
    logic        ISSUE_V;
    logic [4:0]  ISSUE_RD;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic        HAZARD;
    logic [31:0] BUSY;

    int   total = 0;
    int   bad   = 0;
    logic expect_viol = 1'b0;

    rf_wb_arbiter dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .REQ_V    (REQ_V),
        .REQ_RD   (REQ_RD),
        .REQ_D    (REQ_D),
        .REQ_RDY  (REQ_RDY),
        .WE       (WE),
        .AW       (AW),
        .D        (D),
        .ISSUE_V  (ISSUE_V),
        .ISSUE_RD (ISSUE_RD),
        .RS1      (RS1),
        .RS2      (RS2),
        .HAZARD   (HAZARD),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
        REQ_RD[i*5 +: 5]  = rd;
        REQ_D[i*32 +: 32] = d;
    endtask

    task automatic issue(input logic [4:0] rd);
        ISSUE_V  = 1'b1;
        ISSUE_RD = rd;
        tick();
        ISSUE_V  = 1'b0;
        ISSUE_RD = 5'd0;
    endtask

    // Every committed write must target a pending register unless a
    // violation is deliberately staged.
    always @(negedge CLK) begin
        if (RSTN && WE) begin
            total++;
            assert (BUSY[AW] === ~expect_viol) else begin
                bad++;
                $error("FAIL wb_busy observed=%0b expected=%0b aw=%0d", BUSY[AW], ~expect_viol, AW);
            end
        end
    end

    initial begin
        RSTN = 1'b0; REQ_V = 3'b001; REQ_RD = 15'd0; REQ_D = 96'd0;
        ISSUE_V = 1'b0; ISSUE_RD = 5'd0; RS1 = 5'd0; RS2 = 5'd0;
        #2;
        chk("rst_we",   64'(WE),      64'd0);
        chk("rst_busy", 64'(BUSY),    64'd0);
        chk("rst_rdy",  64'(REQ_RDY), 64'd0);
        tick(); tick();
        RSTN = 1'b1; REQ_V = 3'b000;

        // Make destinations pending for the round-robin writes.
        issue(5'd1); issue(5'd2); issue(5'd3); issue(5'd10); issue(5'd11);
        chk("issue_busy", 64'(BUSY), 64'h0000_0C0E);

        // Round-robin from pointer 0.
        set_req(0, 5'd1, 32'hA1); set_req(1, 5'd2, 32'hA2); set_req(2, 5'd3, 32'hA3);
        REQ_V = 3'b111; #1;
        chk("rr_g0", 64'(REQ_RDY), 64'b001);
        tick();
        chk("rr_we1", 64'(WE), 64'd1);
        chk("rr_aw1", 64'(AW), 64'd1);
        chk("rr_d1",  64'(D),  64'hA1);
        set_req(0, 5'd10, 32'hB0); #1;
        chk("rr_g1", 64'(REQ_RDY), 64'b010);
        tick();
        chk("rr_aw2", 64'(AW), 64'd2);
        chk("rr_d2",  64'(D),  64'hA2);
        REQ_V = 3'b101; #1;
        chk("rr_g2", 64'(REQ_RDY), 64'b100);
        tick();
        chk("rr_aw3", 64'(AW), 64'd3);
        set_req(2, 5'd11, 32'hB2); #1;
        chk("rr_g3", 64'(REQ_RDY), 64'b001);
        tick();
        chk("rr_aw10", 64'(AW), 64'd10);
        chk("rr_d10",  64'(D),  64'hB0);
        REQ_V = 3'b100; #1;
        chk("rr_g4", 64'(REQ_RDY), 64'b100);
        tick();
        chk("rr_aw11", 64'(AW), 64'd11);
        chk("rr_we11", 64'(WE), 64'd1);
        REQ_V = 3'b000; #1;
        chk("rr_none", 64'(REQ_RDY), 64'b000);
        tick();
        chk("rr_we_off", 64'(WE),   64'd0);
        chk("rr_busy",   64'(BUSY), 64'd0);

        // Single write: issue x5, ALU retires it.
        issue(5'd5);
        chk("sw_busy_set", 64'(BUSY), 64'h20);
        set_req(0, 5'd5, 32'hDEADBEEF);
        REQ_V = 3'b001; #1;
        chk("sw_rdy", 64'(REQ_RDY), 64'b001);
        tick();
        REQ_V = 3'b000;
        chk("sw_we", 64'(WE), 64'd1);
        chk("sw_aw", 64'(AW), 64'd5);
        chk("sw_d",  64'(D),  64'hDEADBEEF);
        chk("sw_busy_hold", 64'(BUSY), 64'h20);
        tick();
        chk("sw_busy_clr", 64'(BUSY), 64'd0);
        chk("sw_we_off",   64'(WE),   64'd0);

        // Hazards.
        issue(5'd7);
        chk("hz_busy7", 64'(BUSY), 64'h80);
        ISSUE_V = 1'b1; ISSUE_RD = 5'd9; RS1 = 5'd7; #1;
        chk("hz_rs1", 64'(HAZARD), 64'd1);
        tick();
        chk("hz_stall", 64'(BUSY), 64'h80);
        ISSUE_V = 1'b0; RS1 = 5'd0; ISSUE_RD = 5'd7; #1;
        chk("hz_waw", 64'(HAZARD), 64'd1);
        ISSUE_RD = 5'd0; RS2 = 5'd7; #1;
        chk("hz_rs2", 64'(HAZARD), 64'd1);
        RS2 = 5'd0; #1;
        chk("hz_zero", 64'(HAZARD), 64'd0);
        set_req(1, 5'd7, 32'h77);
        REQ_V = 3'b010; #1;
        chk("hz_lsu_rdy", 64'(REQ_RDY), 64'b010);
        tick();
        REQ_V = 3'b000;
        chk("hz_lsu_aw", 64'(AW), 64'd7);
        tick();
        chk("hz_clean", 64'(BUSY), 64'd0);

        // Same-edge set and clear of x4 (write staged without a pending entry).
        set_req(0, 5'd4, 32'h44);
        REQ_V = 3'b001; #1;
        chk("se_rdy", 64'(REQ_RDY), 64'b001);
        tick();
        REQ_V = 3'b000; expect_viol = 1'b1;
        chk("se_aw", 64'(AW), 64'd4);
        ISSUE_V = 1'b1; ISSUE_RD = 5'd4; RS1 = 5'd6; RS2 = 5'd6; #1;
        chk("se_nohz", 64'(HAZARD), 64'd0);
        tick();
        expect_viol = 1'b0; ISSUE_V = 1'b0; ISSUE_RD = 5'd0; RS1 = 5'd0; RS2 = 5'd0;
        chk("se_busy", 64'(BUSY), 64'h10);

        // Write to x0 from MDU.
        set_req(2, 5'd0, 32'h1234);
        REQ_V = 3'b100; #1;
        chk("x0_rdy", 64'(REQ_RDY), 64'b100);
        tick();
        REQ_V = 3'b000;
        chk("x0_we", 64'(WE), 64'd0);
        chk("x0_d",  64'(D),  64'h1234);
        tick();
        chk("x0_busy", 64'(BUSY), 64'h10);

        // Asynchronous reset with a request in flight.
        set_req(0, 5'd4, 32'h55);
        REQ_V = 3'b001; #1;
        chk("ar_rdy", 64'(REQ_RDY), 64'b001);
        tick();
        chk("ar_we_pre", 64'(WE), 64'd1);
        RSTN = 1'b0; #1;
        chk("ar_we",   64'(WE),      64'd0);
        chk("ar_aw",   64'(AW),      64'd0);
        chk("ar_d",    64'(D),       64'd0);
        chk("ar_busy", 64'(BUSY),    64'd0);
        chk("ar_rdy0", 64'(REQ_RDY), 64'b000);
        REQ_V = 3'b000;
        tick(); tick();
        RSTN = 1'b1;
        REQ_V = 3'b111; #1;
        chk("ar_ptr", 64'(REQ_RDY), 64'b001);
        REQ_V = 3'b000; #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
